// File: rtl/conv_pkg.sv
// Shared types and helpers for the 1-D convolution controller.
package conv_pkg;

  typedef enum logic [1:0] {LOAD, CLEAR, MAC, OUT} conv_state_t;

  // Number of fully overlapping output positions for a frame.
  function automatic int num_y(input int data_n, input int filter_n);
    return data_n - filter_n + 1;
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Up-counter from 0 to LIMIT with synchronous reset, clear and wrap on increment at LIMIT.
module mod_counter #(
  parameter int WIDTH = 3,
  parameter int LIMIT = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             at_max
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  assign at_max = (count_q == WIDTH'(LIMIT));
  assign count  = count_q;

  // Clear wins over increment so a frame-end clear cannot be lost to a stray inc.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc) begin
      count_d = at_max ? '0 : count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/conv_ctrl.sv
// Control FSM for the 1-D convolution datapath: loads x/f, runs the MAC loop, hands out results.
// Build option CONV_KEEP_FILTER_EN keeps the filter loaded across frames once it has been loaded.
module conv_ctrl
  import conv_pkg::*;
#(
  parameter int DATA_N      = 8,
  parameter int FILTER_N    = 4,
  parameter int LG_DATA_N   = 3,
  parameter int LG_FILTER_N = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   s_valid_x,
  output logic                   s_ready_x,
  input  logic                   s_valid_f,
  output logic                   s_ready_f,
  output logic [LG_DATA_N-1:0]   addr_x,
  output logic                   wr_en_x,
  output logic [LG_FILTER_N-1:0] addr_f,
  output logic                   wr_en_f,
  output logic                   clear_acc,
  output logic                   en_acc,
  output logic                   m_valid_y,
  input  logic                   m_ready_y,
  output conv_state_t            dbg_state
);

  localparam int NUM_Y = num_y(DATA_N, FILTER_N);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // Ready never depends on valid; a producer holds valid and data until the transfer.

  conv_state_t            state_q;
  conv_state_t            state_d;

  logic [LG_DATA_N:0]     cnt_x;
  logic [LG_FILTER_N:0]   cnt_f;
  logic [LG_DATA_N-1:0]   j;
  logic [LG_FILTER_N-1:0] k;
  logic                   x_full;
  logic                   f_full;
  logic                   j_last;
  logic                   k_last;
  logic                   inc_x;
  logic                   inc_f;
  logic                   inc_j;
  logic                   inc_k;
  logic                   clr_k;
  logic                   clr_f;
  logic                   frame_done;

`ifdef CONV_KEEP_FILTER_EN
  assign clr_f = 1'b0;
`else
  assign clr_f = frame_done;
`endif

  mod_counter #(.WIDTH(LG_DATA_N + 1), .LIMIT(DATA_N)) u_cnt_x (
    .clk(clk), .reset(reset), .clear(frame_done), .inc(inc_x), .count(cnt_x), .at_max(x_full)
  );

  mod_counter #(.WIDTH(LG_FILTER_N + 1), .LIMIT(FILTER_N)) u_cnt_f (
    .clk(clk), .reset(reset), .clear(clr_f), .inc(inc_f), .count(cnt_f), .at_max(f_full)
  );

  mod_counter #(.WIDTH(LG_DATA_N), .LIMIT(NUM_Y - 1)) u_cnt_j (
    .clk(clk), .reset(reset), .clear(frame_done), .inc(inc_j), .count(j), .at_max(j_last)
  );

  mod_counter #(.WIDTH(LG_FILTER_N), .LIMIT(FILTER_N - 1)) u_cnt_k (
    .clk(clk), .reset(reset), .clear(clr_k), .inc(inc_k), .count(k), .at_max(k_last)
  );

  always_comb begin
    state_d    = state_q;
    s_ready_x  = 1'b0;
    s_ready_f  = 1'b0;
    wr_en_x    = 1'b0;
    wr_en_f    = 1'b0;
    addr_x     = '0;
    addr_f     = '0;
    clear_acc  = 1'b0;
    en_acc     = 1'b0;
    m_valid_y  = 1'b0;
    inc_x      = 1'b0;
    inc_f      = 1'b0;
    inc_j      = 1'b0;
    inc_k      = 1'b0;
    clr_k      = 1'b0;
    frame_done = 1'b0;
    unique case (state_q)
      LOAD: begin
        s_ready_x = !x_full;
        s_ready_f = !f_full;
        wr_en_x   = s_valid_x & s_ready_x;
        wr_en_f   = s_valid_f & s_ready_f;
        addr_x    = LG_DATA_N'(cnt_x);
        addr_f    = LG_FILTER_N'(cnt_f);
        inc_x     = wr_en_x;
        inc_f     = wr_en_f;
        if (x_full && f_full) begin
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        clear_acc = 1'b1;
        clr_k     = 1'b1;
        state_d   = MAC;
      end
      MAC: begin
        // j + k stays below DATA_N because j never exceeds DATA_N - FILTER_N.
        en_acc  = 1'b1;
        addr_x  = j + LG_DATA_N'(k);
        addr_f  = k;
        inc_k   = 1'b1;
        if (k_last) begin
          state_d = OUT;
        end
      end
      OUT: begin
        m_valid_y = 1'b1;
        if (m_ready_y) begin
          if (j_last) begin
            frame_done = 1'b1;
            state_d    = LOAD;
          end else begin
            inc_j   = 1'b1;
            state_d = CLEAR;
          end
        end
      end
      default: state_d = LOAD;
    endcase
    if (reset) begin
      s_ready_x = 1'b0;
      s_ready_f = 1'b0;
      wr_en_x   = 1'b0;
      wr_en_f   = 1'b0;
      addr_x    = '0;
      addr_f    = '0;
      clear_acc = 1'b0;
      en_acc    = 1'b0;
      m_valid_y = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  assign dbg_state = reset ? LOAD : state_q;

endmodule

// File: tb/tb_conv_ctrl.sv
// Directed bench for conv_ctrl with a behavioural datapath (memories, 8x8 multiply, 21-bit accumulator).
// Build with CONV_KEEP_FILTER_EN to exercise the filter-retention frame.
module tb_conv_ctrl;
  import conv_pkg::*;

  localparam int DATA_N      = 8;
  localparam int FILTER_N    = 4;
  localparam int LG_DATA_N   = 3;
  localparam int LG_FILTER_N = 2;
  localparam int NUM_Y       = 5;

  typedef logic [7:0]  vec_x_t [DATA_N];
  typedef logic [7:0]  vec_f_t [FILTER_N];
  typedef logic [31:0] vec_y_t [NUM_Y];

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic                   s_valid_x = 1'b0;
  logic                   s_valid_f = 1'b0;
  logic                   m_ready_y = 1'b1;
  logic [7:0]             s_data_x = '0;
  logic [7:0]             s_data_f = '0;
  logic                   s_ready_x;
  logic                   s_ready_f;
  logic [LG_DATA_N-1:0]   addr_x;
  logic [LG_FILTER_N-1:0] addr_f;
  logic                   wr_en_x;
  logic                   wr_en_f;
  logic                   clear_acc;
  logic                   en_acc;
  logic                   m_valid_y;
  conv_state_t            dbg_state;

  conv_ctrl #(
    .DATA_N(DATA_N), .FILTER_N(FILTER_N), .LG_DATA_N(LG_DATA_N), .LG_FILTER_N(LG_FILTER_N)
  ) dut (
    .clk(clk), .reset(reset),
    .s_valid_x(s_valid_x), .s_ready_x(s_ready_x),
    .s_valid_f(s_valid_f), .s_ready_f(s_ready_f),
    .addr_x(addr_x), .wr_en_x(wr_en_x),
    .addr_f(addr_f), .wr_en_f(wr_en_f),
    .clear_acc(clear_acc), .en_acc(en_acc),
    .m_valid_y(m_valid_y), .m_ready_y(m_ready_y),
    .dbg_state(dbg_state)
  );

  // ---------------- datapath model ----------------
  logic signed [7:0]  mem_x [DATA_N];
  logic signed [7:0]  mem_f [FILTER_N];
  logic signed [15:0] prod;
  logic signed [20:0] acc;

  assign prod = mem_x[addr_x] * mem_f[addr_f];

  always @(posedge clk) begin
    if (wr_en_x) mem_x[addr_x] <= s_data_x;
    if (wr_en_f) mem_f[addr_f] <= s_data_f;
    if (clear_acc) acc <= '0;
    else if (en_acc) acc <= acc + {{5{prod[15]}}, prod};
  end

  function automatic logic [31:0] acc_ext();
    return {{11{acc[20]}}, acc};
  endfunction

  function automatic logic [31:0] all_outs();
    return 32'({s_ready_x, s_ready_f, wr_en_x, wr_en_f, clear_acc, en_acc, m_valid_y,
                addr_x, addr_f, dbg_state});
  endfunction

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  int          got_cyc_q[$];
  int          last_wr_cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
`ifdef CONV_KEEP_FILTER_EN
  bit          f_loaded = 1'b0;
`endif

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, $signed(got), got,
               $signed(exp), exp);
    end
  endtask

  // Samples 2 ns after the falling edge, well clear of the rising edge.
  always begin
    @(negedge clk);
    #2;
    if (!reset) begin
      if (m_valid_y && m_ready_y) begin
        got_q.push_back(acc_ext());
        got_cyc_q.push_back(cyc);
      end
      if (s_valid_x && !s_ready_x) check_val("x_ignored_wr_en", 32'(wr_en_x), 32'd0);
      if (s_valid_f && !s_ready_f) check_val("f_ignored_wr_en", 32'(wr_en_f), 32'd0);
      if (wr_en_x || wr_en_f) last_wr_cyc = cyc;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_x(input vec_x_t v, input int gap_max, input bit hold_junk);
    int gap;
    int wait_n;
    for (int i = 0; i < DATA_N; i++) begin
      gap = $urandom_range(gap_max, 0);
      repeat (gap) begin
        @(negedge clk);
        s_valid_x = 1'b0;
      end
      @(negedge clk);
      s_valid_x = 1'b1;
      s_data_x  = v[i];
      wait_n    = 0;
      #1;
      while (!s_ready_x && wait_n < 60) begin
        @(negedge clk);
        #1;
        wait_n++;
      end
      if (!s_ready_x) check_val("x_accept_timeout", 32'(s_ready_x), 32'd1);
    end
    @(negedge clk);
    if (hold_junk) begin
      s_valid_x = 1'b1;
      s_data_x  = 8'h63;
    end else begin
      s_valid_x = 1'b0;
    end
  endtask

  task automatic send_f(input vec_f_t v, input int gap_max);
    int gap;
    int wait_n;
    for (int i = 0; i < FILTER_N; i++) begin
      gap = $urandom_range(gap_max, 0);
      repeat (gap) begin
        @(negedge clk);
        s_valid_f = 1'b0;
      end
      @(negedge clk);
      s_valid_f = 1'b1;
      s_data_f  = v[i];
      wait_n    = 0;
      #1;
      while (!s_ready_f && wait_n < 60) begin
        @(negedge clk);
        #1;
        wait_n++;
      end
      if (!s_ready_f) check_val("f_accept_timeout", 32'(s_ready_f), 32'd1);
    end
    @(negedge clk);
    s_valid_f = 1'b0;
  endtask

  task automatic run_frame(input vec_x_t xv, input vec_f_t fv, input int gap_max,
                           input bit junk_x, input int f_delay);
    bit do_f;
`ifdef CONV_KEEP_FILTER_EN
    do_f = !f_loaded;
`else
    do_f = 1'b1;
`endif
    fork
      send_x(xv, gap_max, junk_x);
      begin
        if (do_f) begin
          repeat (f_delay) @(negedge clk);
          send_f(fv, gap_max);
        end
      end
    join
`ifdef CONV_KEEP_FILTER_EN
    if (do_f) f_loaded = 1'b1;
`endif
  endtask

  task automatic wait_outputs(input int n);
    int budget;
    budget = 0;
    while (got_q.size() < n && budget < 400) begin
      @(negedge clk);
      budget++;
    end
    check_val("outputs_arrived", 32'(got_q.size() >= n), 32'd1);
  endtask

  task automatic collect_frame(input vec_y_t e, input string tag);
    foreach (e[i]) exp_q.push_back(e[i]);
    wait_outputs(NUM_Y);
    repeat (2) @(negedge clk);
    check_val({tag, "_count"}, 32'(got_q.size()), 32'(NUM_Y));
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      check_val(tag, got_q.pop_front(), exp_q.pop_front());
    end
    exp_q.delete();
    got_q.delete();
    got_cyc_q.delete();
  endtask

  task automatic wait_signal(input string tag, input bit want_valid);
    int budget;
    budget = 0;
    #1;
    while ((want_valid ? !m_valid_y : !en_acc) && budget < 60) begin
      @(negedge clk);
      #1;
      budget++;
    end
    check_val(tag, 32'(want_valid ? m_valid_y : en_acc), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: end of test not reached, expected finish before 500 us");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    vec_x_t      x_ramp;
    vec_x_t      x_ramp2;
    vec_x_t      x_neg;
    vec_f_t      f_ones;
    vec_f_t      f_mix;
    vec_f_t      f_neg;
    vec_y_t      y_ones;
    vec_y_t      y_mix;
    vec_y_t      y_keep;
    vec_y_t      y_neg;
    logic [31:0] held_y;

    for (int i = 0; i < DATA_N; i++) begin
      x_ramp[i]  = 8'(i + 1);
      x_ramp2[i] = 8'(i + 2);
      x_neg[i]   = 8'h80;
    end
    f_ones = '{8'd1, 8'd1, 8'd1, 8'd1};
    f_mix  = '{8'd1, 8'hFF, 8'd2, 8'd0};
    f_neg  = '{8'h80, 8'h80, 8'h80, 8'h80};
    y_ones = '{32'd10, 32'd14, 32'd18, 32'd22, 32'd26};
    y_mix  = '{32'd5, 32'd7, 32'd9, 32'd11, 32'd13};
    y_keep = '{32'd14, 32'd18, 32'd22, 32'd26, 32'd30};
    y_neg  = '{32'd65536, 32'd65536, 32'd65536, 32'd65536, 32'd65536};

    // Reset with valids high: nothing may be accepted or written.
    reset     = 1'b1;
    s_valid_x = 1'b1;
    s_valid_f = 1'b1;
    m_ready_y = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_val("reset_outputs", all_outs(), 32'd0);
    @(negedge clk);
    reset     = 1'b0;
    s_valid_x = 1'b0;
    s_valid_f = 1'b0;
    #1;
    check_val("ready_after_reset", 32'({s_ready_x, s_ready_f, m_valid_y}), 32'b110);

    // Frame 1: ramp * ones; x stays valid with junk after its load and must be ignored.
    run_frame(x_ramp, f_ones, 0, 1'b1, 10);
    wait_outputs(1);
    @(negedge clk);
    s_valid_x = 1'b0;
    wait_outputs(NUM_Y);
    check_val("first_latency", 32'(got_cyc_q[0] - last_wr_cyc), 32'(FILTER_N + 3));
    for (int i = 1; i < NUM_Y; i++) begin
      check_val("y_period", 32'(got_cyc_q[i] - got_cyc_q[i-1]), 32'(FILTER_N + 2));
    end
    collect_frame(y_ones, "y_ones");

    // Frame 2: random input gaps, consumer stalls output 2 for three cycles.
    run_frame(x_ramp, f_ones, 3, 1'b0, 0);
    wait_outputs(1);
    m_ready_y = 1'b0;
    wait_signal("stall_valid_seen", 1'b1);
    held_y = acc_ext();
    check_val("stall_y_value", held_y, 32'd14);
    repeat (3) begin
      @(negedge clk);
      #1;
      check_val("stall_valid_held", 32'(m_valid_y), 32'd1);
      check_val("stall_y_held", acc_ext(), held_y);
    end
    m_ready_y = 1'b1;
    collect_frame(y_ones, "y_gaps");

`ifdef CONV_KEEP_FILTER_EN
    // Filter retained: junk coefficients are offered but never taken.
    @(negedge clk);
    s_valid_f = 1'b1;
    s_data_f  = 8'h55;
    #1;
    check_val("keep_ready_f", 32'(s_ready_f), 32'd0);
    run_frame(x_ramp2, f_ones, 0, 1'b0, 0);
    collect_frame(y_keep, "y_keep");
    s_valid_f = 1'b0;
`else
    run_frame(x_ramp, f_mix, 0, 1'b0, 0);
    collect_frame(y_mix, "y_mix");
`endif

    // Reset in the middle of the third output's MAC loop.
    run_frame(x_ramp, f_ones, 0, 1'b0, 0);
    wait_outputs(2);
    check_val("pre_reset_y0", got_q[0], 32'd10);
    check_val("pre_reset_y1", got_q[1], 32'd14);
    wait_signal("mac_reached", 1'b0);
    reset = 1'b1;
    #1;
    check_val("reset_in_mac", all_outs(), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_val("ready_after_mac_reset", 32'({s_ready_x, s_ready_f, m_valid_y, en_acc}), 32'b1100);
    got_q.delete();
    got_cyc_q.delete();
`ifdef CONV_KEEP_FILTER_EN
    f_loaded = 1'b0;
`endif
    run_frame(x_neg, f_neg, 0, 1'b0, 0);
    collect_frame(y_neg, "y_neg");

    // Reset while an output is waiting for the consumer.
    m_ready_y = 1'b0;
    run_frame(x_ramp, f_neg, 0, 1'b0, 0);
    wait_signal("out_wait_valid", 1'b1);
    check_val("out_wait_y", acc_ext(), 32'hFFFF_FB00);  // -128 * (1+2+3+4)
    reset = 1'b1;
    #1;
    check_val("reset_in_out", all_outs(), 32'd0);
    @(negedge clk);
    reset     = 1'b0;
    m_ready_y = 1'b1;
    #1;
    check_val("ready_after_out_reset", 32'({s_ready_x, s_ready_f, m_valid_y}), 32'b110);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_ctrl.md
Name: conv_ctrl

Overview:
Control FSM for the 1-D convolution unit; sits directly upstream of the convolution datapath and drives its memory addresses, write enables and accumulator controls.
Accepts DATA_N input samples and FILTER_N coefficients over valid/ready streams, then sequences the MAC loop, producing NUM_Y = DATA_N-FILTER_N+1 outputs.
Presents each accumulator result to the consumer with a valid/ready handshake.

Parameters:
DATA_N, 8, number of input samples per frame
FILTER_N, 4, number of filter taps (FILTER_N <= DATA_N)
LG_DATA_N, 3, address width of data memory
LG_FILTER_N, 2, address width of filter memory

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
s_valid_x  in  1  input sample valid (data itself goes straight to datapath s_data_x)
s_ready_x  out  1  controller accepts x sample this cycle
s_valid_f  in  1  coefficient valid (data goes to datapath s_data_f)
s_ready_f  out  1  controller accepts coefficient this cycle
addr_x  out  LG_DATA_N  data memory address
wr_en_x  out  1  data memory write enable
addr_f  out  LG_FILTER_N  filter memory address
wr_en_f  out  1  filter memory write enable
clear_acc  out  1  clear accumulator (precedence over en_acc)
en_acc  out  1  accumulate current product
m_valid_y  out  1  datapath m_data_out_y holds a finished output
m_ready_y  in  1  consumer accepts output

Behaviour:
- Interface contract: datapath memories read combinationally; accumulator registers on clk when clear_acc or en_acc.
- Registers: state, cnt_x (0..DATA_N), cnt_f (0..FILTER_N), j (output index 0..NUM_Y-1), k (tap 0..FILTER_N-1).
- States: LOAD, CLEAR, MAC, OUT. Reset -> LOAD, all counters 0.
- While reset is high, every output is 0.
- LOAD:
  - s_ready_x = (cnt_x < DATA_N); s_ready_f = (cnt_f < FILTER_N).
  - wr_en_x = s_valid_x & s_ready_x, addr_x = cnt_x; wr_en_f = s_valid_f & s_ready_f, addr_f = cnt_f.
  - Both streams load independently and may write in the same cycle.
  - Each counter increments on its handshake.
  - When both counters are full (checked on registered values) -> CLEAR.
- CLEAR: clear_acc=1 for one cycle, k=0 -> MAC.
- MAC:
  - en_acc=1, addr_x = j+k (never exceeds DATA_N-1), addr_f = k.
  - k increments each cycle.
  - At k = FILTER_N-1 -> OUT.
- OUT:
  - m_valid_y=1; hold m_valid_y high until m_ready_y; accumulator untouched while waiting.
  - On handshake, if j = NUM_Y-1: j=0, cnt_x=0, cnt_f=0 -> LOAD.
  - Otherwise j++ -> CLEAR.
- All s_ready/wr_en are 0 outside LOAD; en_acc/clear_acc/m_valid_y are 0 outside their states.
- Latency: first m_valid_y exactly FILTER_N+1 cycles after leaving LOAD; FILTER_N+2 cycles per output with m_ready_y tied high.
- Arithmetic: the 16-bit product sign-extends into the 21-bit accumulator; the controller does no arithmetic beyond index add j+k (LG_DATA_N bits).
- Boundaries:
  - FILTER_N = DATA_N gives a single output.
  - s_valid held while s_ready=0 is ignored (no write).
  - Reset in any state (including OUT with m_valid_y high) drops all outputs and returns to LOAD the next cycle; memory contents are not relied upon.

Optional Feature:
Macro CONV_KEEP_FILTER_EN.
- Defined: after the first completed filter load following reset, cnt_f stays at FILTER_N at frame end; s_ready_f stays 0 and later frames load only x.
- Undefined: filter is reloaded every frame as above.

Decomposition:
- Package conv_pkg holds:
  - typedef enum logic [1:0] {LOAD, CLEAR, MAC, OUT} conv_state_t.
  - Function num_y(DATA_N, FILTER_N).
- One natural sub-module, mod_counter (width/limit parameters, clear, inc, at_max).
- mod_counter is instanced for cnt_x, cnt_f, j, k.

Test Plan:
- x=1..8, f=1,1,1,1, m_ready_y=1 -> y = 10,14,18,22,26; each m_valid_y pulse 6 cycles apart.
- x=1..8, f=1,-1,2,0 -> y = 5,7,9,11,13.
- x all -128, f all -128 -> every y = 65536 (no overflow in 21 bits).
- Random s_valid gaps plus m_ready_y low for 3 cycles on output 2 -> m_valid_y holds and the y value is unchanged; results match the first scenario.
- Reset asserted during MAC of output 3 -> all outputs 0 in that cycle; s_ready_x=1 next cycle; full reload gives correct results.
- CONV_KEEP_FILTER_EN defined: second frame x=2..9 with no f traffic and s_ready_f=0 -> y = 14,18,22,26,30.
